// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - operand FIFO and burst sequencer feeding PE0 of the systolic chain
module systolic_feeder #(
  parameter int vector_size = 8,
  parameter int DEPTH       = 16,
  parameter int NUM_PE      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [vector_size-1:0]   in_data,
  output logic                     in_ready,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   burst_len,
  input  logic [vector_size-1:0]   bias,
  output logic [vector_size-1:0]   x_feed,
  output logic [vector_size-1:0]   y_feed,
  output logic                     feed_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(NUM_PE + 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH} state_t;

  logic [vector_size-1:0] mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q;
  logic                   push, pop;

  state_t                 state_q, state_d;
  logic [CW-1:0]          remaining_q, remaining_d;
  logic [FW-1:0]          flush_q, flush_d;
  logic [vector_size-1:0] bias_q, bias_d;
  logic [vector_size-1:0] x_q, x_d, y_q, y_d;
  logic                   fv_q, fv_d, busy_q, done_q, done_d;

  // Ready follows the registered occupancy only, so a same-cycle pop never opens a slot.
  assign in_ready = !reset && (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;

  // Operand storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Next-state and next-output logic for the IDLE/FEED/FLUSH sequencer.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    flush_d     = flush_q;
    bias_d      = bias_q;
    x_d         = '0;
    y_d         = '0;
    fv_d        = 1'b0;
    done_d      = 1'b0;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (burst_len != '0)) begin
          remaining_d = (burst_len > CW'(DEPTH)) ? CW'(DEPTH) : burst_len;
          bias_d      = bias;
          state_d     = S_FEED;
        end
      end
      S_FEED: begin
        // An empty FIFO produces a bubble that leaves the remaining count untouched.
        if (count_q != '0) begin
          pop         = 1'b1;
          x_d         = mem_q[rd_ptr_q];
          y_d         = bias_q;
          fv_d        = 1'b1;
          remaining_d = remaining_q - CW'(1);
          if (remaining_q == CW'(1)) begin
            state_d = S_FLUSH;
            flush_d = FW'(NUM_PE);
          end
        end
      end
      S_FLUSH: begin
        flush_d = flush_q - FW'(1);
        if (flush_q == FW'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and registered outputs; busy tracks the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      flush_q     <= '0;
      bias_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      fv_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      flush_q     <= flush_d;
      bias_q      <= bias_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fv_q        <= fv_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= done_d;
    end
  end

  assign x_feed     = x_q;
  assign y_feed     = y_q;
  assign feed_valid = fv_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed self-checking bench for systolic_feeder
module tb_systolic_feeder;

  logic       clk, reset, in_valid, in_ready, start, feed_valid, busy, done;
  logic [7:0] in_data, bias, x_feed, y_feed;
  logic [4:0] burst_len;

  int tests, fails;
  logic [7:0] got [$];
  int nv, nd;

  systolic_feeder #(.vector_size(8), .DEPTH(16), .NUM_PE(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start(start), .burst_len(burst_len), .bias(bias), .x_feed(x_feed), .y_feed(y_feed),
    .feed_valid(feed_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] len, input logic [7:0] b);
    start     = 1'b1;
    burst_len = len;
    bias      = b;
    tick();
    start     = 1'b0;
  endtask

  // Gathers fed words until done (bounded); nd stays 0 on timeout.
  task automatic collect(input int max_cycles, input logic [7:0] b, output int n_v, output int n_d);
    n_v = 0;
    n_d = 0;
    for (int c = 0; c < max_cycles; c++) begin
      tick();
      if (feed_valid) begin
        got.push_back(x_feed);
        n_v++;
        if (y_feed !== b) chk("collect_y", 32'(y_feed), 32'(b));
      end
      if (done) begin
        n_d++;
        break;
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; in_valid = 1'b1; in_data = 8'hAA; start = 1'b0; burst_len = '0; bias = '0;

    // Reset held two cycles with a pending write.
    tick();
    chk("rst_x", 32'(x_feed), 0);
    chk("rst_y", 32'(y_feed), 0);
    chk("rst_fv", 32'(feed_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    tick();
    chk("rst_count", 32'(dut.count_q), 0);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // Basic burst: 3,5,7 with bias 2, then four zero cycles.
    push_word(8'd3); push_word(8'd5); push_word(8'd7);
    do_start(5'd3, 8'd2);
    chk("basic_e0_busy", 32'(busy), 1);
    chk("basic_e0_fv", 32'(feed_valid), 0);
    tick(); chk("basic_x1", 32'(x_feed), 3); chk("basic_y1", 32'(y_feed), 2); chk("basic_fv1", 32'(feed_valid), 1);
    tick(); chk("basic_x2", 32'(x_feed), 5); chk("basic_fv2", 32'(feed_valid), 1);
    tick(); chk("basic_x3", 32'(x_feed), 7); chk("basic_y3", 32'(y_feed), 2); chk("basic_fv3", 32'(feed_valid), 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("basic_flush_fv", 32'(feed_valid), 0);
      chk("basic_flush_x", 32'(x_feed), 0);
      chk("basic_flush_y", 32'(y_feed), 0);
      chk("basic_flush_done", 32'(done), (i == 4) ? 1 : 0);
      chk("basic_flush_busy", 32'(busy), (i == 4) ? 0 : 1);
    end
    tick(); chk("basic_done_pulse", 32'(done), 0);

    // Full FIFO: 17 back-to-back offers, only 16 accepted.
    for (int i = 1; i <= 17; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
      if (i == 16) chk("full_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    chk("full_count", 32'(dut.count_q), 16);
    got.delete();
    do_start(5'd16, 8'h11);
    collect(60, 8'h11, nv, nd);
    chk("full_nv", 32'(nv), 16);
    chk("full_nd", 32'(nd), 1);
    for (int i = 0; i < 16; i++) chk("full_word", 32'(got[i]), 32'(i + 1));

    // Underflow: two words, burst of 4, two more words arrive late.
    push_word(8'd1); push_word(8'd2);
    do_start(5'd4, 8'd9);
    tick(); chk("uf_x1", 32'(x_feed), 1); chk("uf_fv1", 32'(feed_valid), 1); chk("uf_y1", 32'(y_feed), 9);
    tick(); chk("uf_x2", 32'(x_feed), 2); chk("uf_fv2", 32'(feed_valid), 1);
    tick(); chk("uf_bub_fv", 32'(feed_valid), 0); chk("uf_bub_x", 32'(x_feed), 0);
    chk("uf_bub_y", 32'(y_feed), 0); chk("uf_bub_busy", 32'(busy), 1);
    in_valid = 1'b1; in_data = 8'd3;
    tick(); chk("uf_bub2_fv", 32'(feed_valid), 0);
    in_data = 8'd4;
    tick(); chk("uf_x3", 32'(x_feed), 3); chk("uf_fv3", 32'(feed_valid), 1);
    in_valid = 1'b0;
    tick(); chk("uf_x4", 32'(x_feed), 4); chk("uf_fv4", 32'(feed_valid), 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("uf_flush_fv", 32'(feed_valid), 0);
      chk("uf_flush_done", 32'(done), (i == 4) ? 1 : 0);
    end

    // burst_len == 0 is ignored.
    do_start(5'd0, 8'd5);
    chk("zero_busy", 32'(busy), 0);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) nd++;
    end
    chk("zero_nd", 32'(nd), 0);
    chk("zero_busy_after", 32'(busy), 0);

    // burst_len 20 clamps to DEPTH.
    for (int i = 0; i < 16; i++) push_word(8'(8'h20 + i));
    got.delete();
    do_start(5'd20, 8'h33);
    collect(80, 8'h33, nv, nd);
    chk("clamp_nv", 32'(nv), 16);
    chk("clamp_nd", 32'(nd), 1);
    for (int i = 0; i < 16; i++) chk("clamp_word", 32'(got[i]), 32'(8'h20 + i));
    chk("clamp_count", 32'(dut.count_q), 0);

    // start during FEED has no effect.
    for (int i = 0; i < 4; i++) push_word(8'(8'h40 + i));
    do_start(5'd4, 8'd1);
    tick(); chk("mid_fv1", 32'(feed_valid), 1); chk("mid_x1", 32'(x_feed), 32'h40);
    do_start(5'd2, 8'd7);
    chk("mid_x2", 32'(x_feed), 32'h41);
    got.delete();
    collect(40, 8'd1, nv, nd);
    chk("mid_nv", 32'(nv), 2);
    chk("mid_nd", 32'(nd), 1);
    chk("mid_w3", 32'(got[0]), 32'h42);
    chk("mid_w4", 32'(got[1]), 32'h43);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) nd++;
    end
    chk("mid_no_restart", 32'(nd), 0);

    // Reset on the second feed_valid cycle.
    push_word(8'h51); push_word(8'h52); push_word(8'h53);
    do_start(5'd3, 8'd4);
    tick(); chk("rmid_fv1", 32'(feed_valid), 1);
    tick(); chk("rmid_fv2", 32'(feed_valid), 1);
    reset = 1'b1;
    tick();
    chk("rmid_x", 32'(x_feed), 0);
    chk("rmid_fv", 32'(feed_valid), 0);
    chk("rmid_busy", 32'(busy), 0);
    chk("rmid_done", 32'(done), 0);
    chk("rmid_count", 32'(dut.count_q), 0);
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) nd++;
    end
    chk("rmid_no_done", 32'(nd), 0);
    push_word(8'h77);
    got.delete();
    do_start(5'd1, 8'h05);
    collect(20, 8'h05, nv, nd);
    chk("rmid_again_nv", 32'(nv), 1);
    chk("rmid_again_nd", 32'(nd), 1);
    chk("rmid_again_w", 32'(got[0]), 32'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
